// File: rtl/cache_pkg.sv
// Shared constants and state encoding for the cache memory hierarchy.
package cache_pkg;

  localparam int unsigned LINE_BITS   = 256;
  localparam int unsigned OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ACK  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_memory_array.sv
// Line storage for data_memory: synchronous write, synchronous registered read.
// Contents are never reset; only the read register is.
module data_memory_array
  import cache_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = LINE_BITS,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IdxW-1:0]  idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] memory [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // Storage write port; deliberately has no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[idx_i] <= wdata_i;
    end
  end

  // Read register holds its last value until the next read.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = memory[idx_i];
    end
  end

  // Read register state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Line-granular backing store behind the L1 data cache. One request in flight,
// fixed latency, single-cycle ack pulse. rst_i is active-low asynchronous.
module data_memory
  import cache_pkg::*;
#(
  parameter int unsigned LATENCY     = 10,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned LINE_BITS   = cache_pkg::LINE_BITS,
  parameter int unsigned OFFSET_BITS = cache_pkg::OFFSET_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e state_d, state_q;
  logic [CntW-1:0]      cnt_d, cnt_q;
  logic [IdxW-1:0]      idx_d, idx_q;
  logic [LINE_BITS-1:0] wdata_d, wdata_q;
  logic                 write_d, write_q;
  logic                 ack_d, ack_q;
  logic                 mem_we, mem_re;

  // Offset bits and bits above the index do not select a line (aliasing).
  logic unused_addr;
  assign unused_addr = ^{addr_i[OFFSET_BITS-1:0], addr_i[31:OFFSET_BITS+IdxW]};

  // Next-state: accept in IDLE, count down in WAIT, commit/read on WAIT->ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    ack_d   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (enable_i) begin
          state_d = MEM_WAIT;
          cnt_d   = CntW'(LATENCY - 1);
          idx_d   = addr_i[OFFSET_BITS +: IdxW];
          wdata_d = data_i;
          write_d = write_i;
        end
      end
      MEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d = MEM_ACK;
          ack_d   = 1'b1;
          mem_we  = write_q;
          mem_re  = !write_q;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      // enable_i is ignored here, so back-to-back requests leave one IDLE cycle.
      MEM_ACK: state_d = MEM_IDLE;
      default: state_d = MEM_IDLE;
    endcase
  end

  // FSM, counter, captured request and registered ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      ack_q   <= ack_d;
    end
  end

  data_memory_array #(
    .DEPTH (DEPTH),
    .WIDTH (LINE_BITS)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

  assign ack_o = ack_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: default LATENCY=10 instance plus a LATENCY=1 instance.
module tb_data_memory;
  import cache_pkg::*;

  localparam int LB  = 256;
  localparam int LAT = 10;

  localparam logic [LB-1:0] A5 = {32{8'hA5}};
  localparam logic [LB-1:0] D1 = {8{32'hDEADBEEF}};
  localparam logic [LB-1:0] D2 = {8{32'h0F0F1234}};
  localparam logic [LB-1:0] W1 = 256'h1234;

  logic          clk = 1'b0;
  logic          rst_n, en, wr, ack;
  logic [31:0]   addr;
  logic [LB-1:0] din, dout;
  logic          rst1_n, en1, wr1, ack1;
  logic [31:0]   addr1;
  logic [LB-1:0] din1, dout1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_memory dut (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .addr_i   (addr),
    .data_i   (din),
    .enable_i (en),
    .write_i  (wr),
    .ack_o    (ack),
    .data_o   (dout)
  );

  data_memory #(.LATENCY(1)) dut1 (
    .clk_i    (clk),
    .rst_i    (rst1_n),
    .addr_i   (addr1),
    .data_i   (din1),
    .enable_i (en1),
    .write_i  (wr1),
    .ack_o    (ack1),
    .data_o   (dout1)
  );

  // Drives one request on dut; enable held until ack unless dropped at cycle drop_at.
  task automatic issue(input logic wr_v, input logic [31:0] a, input logic [LB-1:0] d,
                       input int drop_at, output int ack_at, output int n_acks,
                       output logic [LB-1:0] rd, output logic [LB-1:0] line_at_ack);
    ack_at = -1; n_acks = 0; rd = '0; line_at_ack = '0;
    en = 1'b1; wr = wr_v; addr = a; din = d;
    @(posedge clk); #1;
    for (int k = 1; k <= 2 * LAT + 4; k++) begin
      if (k == drop_at) en = 1'b0;
      @(posedge clk); #1;
      if (ack) begin
        n_acks++;
        if (ack_at < 0) begin
          ack_at      = k;
          rd          = dout;
          line_at_ack = dut.u_array.memory[a[13:5]];
        end
        en = 1'b0;
      end
    end
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst1_n = 1'b0;
    en = 0; wr = 0; addr = '0; din = '0;
    en1 = 0; wr1 = 0; addr1 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", ack); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_data: got %h want 0", dout); end
    n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    rst_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int ack_at, n_acks;
    logic [LB-1:0] rd, line;
    issue(1'b1, 32'h60, A5, -1, ack_at, n_acks, rd, line);  // preload line 3
    n_vec++; if (ack_at !== LAT) begin n_err++; $display("FAIL preload_ack_cycle: got %0d want %0d", ack_at, LAT); end
    issue(1'b0, 32'h60, '0, -1, ack_at, n_acks, rd, line);
    n_vec++; if (ack_at !== LAT) begin n_err++; $display("FAIL read_ack_cycle: got %0d want %0d", ack_at, LAT); end
    n_vec++; if (n_acks !== 1) begin n_err++; $display("FAIL read_ack_count: got %0d want 1", n_acks); end
    n_vec++; if (rd !== A5) begin n_err++; $display("FAIL read_data: got %h want %h", rd, A5); end
  endtask

  task automatic test_write_read();
    int ack_at, n_acks;
    logic [LB-1:0] rd, line;
    issue(1'b1, 32'h400, W1, -1, ack_at, n_acks, rd, line);
    n_vec++; if (ack_at !== LAT) begin n_err++; $display("FAIL write_ack_cycle: got %0d want %0d", ack_at, LAT); end
    n_vec++; if (line !== W1) begin n_err++; $display("FAIL write_commit_at_ack: got %h want %h", line, W1); end
    n_vec++; if (dout !== A5) begin n_err++; $display("FAIL write_keeps_data_o: got %h want %h", dout, A5); end
    issue(1'b0, 32'h400, '0, -1, ack_at, n_acks, rd, line);
    n_vec++; if (rd !== W1) begin n_err++; $display("FAIL raw_data: got %h want %h", rd, W1); end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1, n = 0;
    logic [LB-1:0] rd2 = '0;
    en = 1'b1; wr = 1'b1; addr = 32'h80; din = D1;
    @(posedge clk); #1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        din = ~D1; wr = 1'b0; addr = 32'h0;  // mid-WAIT changes must be ignored
      end
      @(posedge clk); #1;
      if (ack) begin
        n++;
        if (first < 0) begin
          first = k; wr = 1'b0; addr = 32'h4080; din = '0;
        end else if (second < 0) begin
          second = k; rd2 = dout; en = 1'b0;
        end
      end
    end
    en = 1'b0;
    n_vec++; if (first !== LAT) begin n_err++; $display("FAIL b2b_first_ack: got %0d want %0d", first, LAT); end
    // ACK cycle plus one IDLE cycle before acceptance: edges 2*LAT+2 apart overall
    n_vec++; if (second !== 2 * LAT + 2) begin n_err++; $display("FAIL b2b_second_ack: got %0d want %0d", second, 2 * LAT + 2); end
    n_vec++; if (n !== 2) begin n_err++; $display("FAIL b2b_ack_count: got %0d want 2", n); end
    n_vec++; if (rd2 !== D1) begin n_err++; $display("FAIL b2b_alias_data: got %h want %h", rd2, D1); end
  endtask

  task automatic test_abort();
    int ack_at, n_acks;
    logic [LB-1:0] rd, line;
    issue(1'b0, 32'h60, '0, 2, ack_at, n_acks, rd, line);
    n_vec++; if (ack_at !== LAT) begin n_err++; $display("FAIL abort_ack_cycle: got %0d want %0d", ack_at, LAT); end
    n_vec++; if (n_acks !== 1) begin n_err++; $display("FAIL abort_ack_count: got %0d want 1", n_acks); end
    n_vec++; if (rd !== A5) begin n_err++; $display("FAIL abort_data: got %h want %h", rd, A5); end
    n_vec++; if (dut.state_q !== MEM_IDLE) begin n_err++; $display("FAIL abort_idle: got %0d want %0d", dut.state_q, MEM_IDLE); end
  endtask

  task automatic test_reset_mid();
    int ack_at, n_acks, seen = 0;
    logic [LB-1:0] rd, line;
    en = 1'b1; wr = 1'b1; addr = 32'h60; din = D2;
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL midrst_ack: got %b want 0", ack); end
    n_vec++; if (dout !== '0) begin n_err++; $display("FAIL midrst_data: got %h want 0", dout); end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL midrst_no_ack: got %0d want 0", seen); end
    n_vec++; if (dut.u_array.memory[3] !== A5) begin
      n_err++; $display("FAIL midrst_line_kept: got %h want %h", dut.u_array.memory[3], A5);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'h60, '0, -1, ack_at, n_acks, rd, line);
    n_vec++; if (ack_at !== LAT) begin n_err++; $display("FAIL postrst_ack_cycle: got %0d want %0d", ack_at, LAT); end
    n_vec++; if (rd !== A5) begin n_err++; $display("FAIL postrst_data: got %h want %h", rd, A5); end
  endtask

  task automatic test_latency1();
    int first = -1, n = 0, consec = 0;
    logic prev = 1'b0;
    logic [LB-1:0] rd = '0;
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h20; din1 = D2;
    @(posedge clk); #1;
    n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL l1_ack_e0: got %b want 0", ack1); end
    @(posedge clk); #1;
    n_vec++; if (ack1 !== 1'b1) begin n_err++; $display("FAIL l1_ack_e1: got %b want 1", ack1); end
    wr1 = 1'b0;  // enable stays high: next request is a read of the same line
    @(posedge clk); #1;
    n_vec++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL l1_ack_e2: got %b want 0", ack1); end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ack1 && prev) consec++;
      if (ack1) begin
        n++;
        if (first < 0) begin first = k; rd = dout1; end
      end
      prev = ack1;
    end
    en1 = 1'b0;
    n_vec++; if (first !== 2) begin n_err++; $display("FAIL l1_read_ack: got %0d want 2", first); end
    n_vec++; if (n !== 4) begin n_err++; $display("FAIL l1_ack_count: got %0d want 4", n); end
    n_vec++; if (consec !== 0) begin n_err++; $display("FAIL l1_consecutive: got %0d want 0", consec); end
    n_vec++; if (rd !== D2) begin n_err++; $display("FAIL l1_read_data: got %h want %h", rd, D2); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_latency1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
